vend_mach: RTL and testbench
============================

Name: vend_mach

Overview:
Single-clock vending-machine controller. It accepts quarter and dollar coin pulses, accumulates credit in quarters, and serves drink or snack selections. On each selection it either dispenses the item and returns change as a quarter count, or flags insufficient credit. It sits between coin/button front-end logic (single-cycle pulses) and the dispenser/change-return actuators.

Parameters:
DRINK_QTRS, 3, drink price in quarters (75 cents)
SNACK_QTRS, 5, snack price in quarters (125 cents)
MAX_QTRS, 10, credit ceiling in quarters (250 cents); MAX_QTRS - DRINK_QTRS must be <= 7

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
qtr  input  1  one-cycle pulse: quarter inserted (+1 quarter)
dlr  input  1  one-cycle pulse: dollar inserted (+4 quarters)
sel_dr  input  1  one-cycle pulse: drink selected
sel_sn  input  1  one-cycle pulse: snack selected
o_drink  output  1  one-cycle pulse: drink dispensed
o_snack  output  1  one-cycle pulse: snack dispensed
coin_err  output  1  one-cycle pulse: selection refused, credit below price
num_chg  output  3  quarters of change; valid with o_drink/o_snack, else 0

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- State: credit register, 4 bits, in quarters, range 0..MAX_QTRS. All outputs are registered.
- Reset: credit=0, o_drink=0, o_snack=0, coin_err=0, num_chg=0. A reset mid-transaction discards credit with no change output.
- Each cycle, the selection is evaluated against the credit held at the start of that cycle.
- sel_dr with credit >= DRINK_QTRS: next cycle o_drink=1 and num_chg=credit-DRINK_QTRS. Credit is cleared to 0 (all change returned).
- sel_sn with credit >= SNACK_QTRS: next cycle o_snack=1 and num_chg=credit-SNACK_QTRS. Credit is cleared to 0.
- Selection with credit below the price: next cycle coin_err=1, num_chg=0. Credit is retained unchanged.
- sel_dr and sel_sn asserted together: drink has priority and sel_sn is ignored.
- Coins: credit += qtr + 4*dlr. qtr and dlr together add 5 quarters.
- Coin in the same cycle as a selection: applied after the selection outcome. It is added to 0 after a dispense, or to the retained credit after an error.
- Cap: if the addition would exceed MAX_QTRS, the whole coin event is rejected and credit is unchanged (coin treated as returned). No output pulse is generated.
- Outputs are pulses: deasserted in every cycle with no qualifying selection. At most one of o_drink/o_snack/coin_err is high in any cycle.
- Holding a select high for multiple cycles is treated as repeated selections, one per cycle.

Decomposition:
- Shared package vend_pkg: prices DRINK_QTRS, SNACK_QTRS, MAX_QTRS; coin values QTR_VAL=1, DLR_VAL=4; credit width constant CREDIT_W=4.
- A single module is sufficient. Optional sub-module vend_credit: credit accumulator with saturation/reject and clear.

Test Plan:
- Reset held 5 cycles -> all outputs 0, credit 0; drink select immediately after -> coin_err pulse, num_chg=0.
- 3 quarters, select snack -> coin_err; then dollar (credit 7), select snack -> o_snack, num_chg=2 (50 cents), credit 0.
- After a dispense: select drink -> coin_err; quarter then drink -> coin_err; quarter then drink -> coin_err; quarter then drink -> o_drink, num_chg=0.
- 2 dollars + 2 quarters (credit 10), then another quarter -> rejected; select drink -> o_drink, num_chg=7.
- qtr and dlr in the same cycle, then select snack -> o_snack, num_chg=0. sel_dr and sel_sn together with credit 5 -> o_drink only, num_chg=2.
- Credit 4 then rst pulse -> credit 0; select drink -> coin_err. Dollar in the same cycle as a successful drink select with credit 3 -> o_drink, num_chg=0, resulting credit 4.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared prices, coin values and types for the vending-machine controller.
// Credit is held in quarters; change is reported in quarters.
package vend_pkg;

  localparam int DRINK_QTRS = 3;
  localparam int SNACK_QTRS = 5;
  localparam int MAX_QTRS   = 10;
  localparam int QTR_VAL    = 1;
  localparam int DLR_VAL    = 4;
  localparam int CREDIT_W   = 4;
  localparam int CHG_W      = 3;

  typedef logic [CREDIT_W-1:0] credit_t;
  typedef logic [CHG_W-1:0]    chg_t;

  localparam credit_t DRINK_C = credit_t'(DRINK_QTRS);
  localparam credit_t SNACK_C = credit_t'(SNACK_QTRS);
  localparam credit_t QTR_C   = credit_t'(QTR_VAL);
  localparam credit_t DLR_C   = credit_t'(DLR_VAL);

  typedef enum logic [1:0] {
    OUT_NONE,
    OUT_DRINK,
    OUT_SNACK,
    OUT_ERR
  } vend_out_e;

  // Quarters contributed by the coin pulses of one cycle.
  function automatic credit_t coin_qtrs(
    input logic qtr,
    input logic dlr
  );
    credit_t q;
    credit_t d;
    q = qtr ? QTR_C : '0;
    d = dlr ? DLR_C : '0;
    return q + d;
  endfunction

endpackage

// File: rtl/vend_credit.sv
// Credit accumulator in quarters with clear-then-add and whole-event reject.
// Ports: clk, rst (sync, high), clr, add (quarters this cycle), credit.
module vend_credit
  import vend_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    clr,
  input  credit_t add,
  output credit_t credit
);

  localparam logic [CREDIT_W:0] MAX_W =
    (CREDIT_W+1)'(MAX_QTRS);

  credit_t           base;
  logic [CREDIT_W:0] sum;
  credit_t           nxt;

  // A dispense clears credit before the
  // coin lands; an overflowing coin event
  // is rejected as a whole.
  always_comb begin
    base = clr ? '0 : credit;
    sum  = {1'b0, base} + {1'b0, add};
    nxt  = base;
    if (sum <= MAX_W)
      nxt = sum[CREDIT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst)
      credit <= '0;
    else
      credit <= nxt;
  end

endmodule

// File: rtl/vend_mach.sv
// Vending-machine controller: evaluates selections against held credit.
// Ports: clk, rst, qtr, dlr, sel_dr, sel_sn -> o_drink, o_snack, coin_err, num_chg.
module vend_mach
  import vend_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             qtr,
  input  logic             dlr,
  input  logic             sel_dr,
  input  logic             sel_sn,
  output logic             o_drink,
  output logic             o_snack,
  output logic             coin_err,
  output logic [CHG_W-1:0] num_chg
);

  credit_t   credit;
  credit_t   add;
  logic      dr_hit;
  logic      dr_miss;
  logic      sn_hit;
  logic      sn_miss;
  logic      clr;
  vend_out_e outc;
  chg_t      chg;

  assign add = coin_qtrs(qtr, dlr);

  // Drink wins when both selects are high,
  // so the snack terms are masked by sel_dr.
  always_comb begin
    dr_hit  = sel_dr && (credit >= DRINK_C);
    dr_miss = sel_dr && (credit <  DRINK_C);
    sn_hit  = !sel_dr && sel_sn
           && (credit >= SNACK_C);
    sn_miss = !sel_dr && sel_sn
           && (credit <  SNACK_C);
  end

  always_comb begin
    outc = OUT_NONE;
    chg  = '0;
    unique case (1'b1)
      dr_hit: begin
        outc = OUT_DRINK;
        chg  = chg_t'(credit - DRINK_C);
      end
      sn_hit: begin
        outc = OUT_SNACK;
        chg  = chg_t'(credit - SNACK_C);
      end
      dr_miss,
      sn_miss: outc = OUT_ERR;
      default: outc = OUT_NONE;
    endcase
  end

  assign clr = dr_hit || sn_hit;

  vend_credit u_credit (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .add    (add),
    .credit (credit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      o_drink  <= 1'b0;
      o_snack  <= 1'b0;
      coin_err <= 1'b0;
      num_chg  <= '0;
    end else begin
      o_drink  <= (outc == OUT_DRINK);
      o_snack  <= (outc == OUT_SNACK);
      coin_err <= (outc == OUT_ERR);
      num_chg  <= chg;
    end
  end

endmodule

// File: tb/tb_vend_mach.sv
// Bench for vend_mach: directed scenarios then random traffic
// checked against a quarter-count reference model.
module tb_vend_mach;

  logic       clk = 1'b0;
  logic       rst;
  logic       qtr;
  logic       dlr;
  logic       sel_dr;
  logic       sel_sn;
  logic       o_drink;
  logic       o_snack;
  logic       coin_err;
  logic [2:0] num_chg;

  int checks = 0;
  int passes = 0;
  int m_credit = 0;

  localparam int DRINK = 3;
  localparam int SNACK = 5;
  localparam int MAXC  = 10;

  vend_mach dut (
    .clk      (clk),
    .rst      (rst),
    .qtr      (qtr),
    .dlr      (dlr),
    .sel_dr   (sel_dr),
    .sel_sn   (sel_sn),
    .o_drink  (o_drink),
    .o_snack  (o_snack),
    .coin_err (coin_err),
    .num_chg  (num_chg)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string tag,
    input int    obs,
    input int    exp
  );
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0d expected=%0d",
                tag, obs, exp);
  endtask

  // One clock: drive, clock, update the model, check.
  task automatic step(
    input logic r,
    input logic q,
    input logic d,
    input logic sd,
    input logic ss,
    input string tag
  );
    int e_dr, e_sn, e_err, e_chg, a;
    rst = r; qtr = q; dlr = d;
    sel_dr = sd; sel_sn = ss;
    @(posedge clk);
    e_dr = 0; e_sn = 0; e_err = 0; e_chg = 0;
    if (r) begin
      m_credit = 0;
    end else begin
      if (sd) begin
        if (m_credit >= DRINK) begin
          e_dr = 1;
          e_chg = m_credit - DRINK;
          m_credit = 0;
        end else e_err = 1;
      end else if (ss) begin
        if (m_credit >= SNACK) begin
          e_sn = 1;
          e_chg = m_credit - SNACK;
          m_credit = 0;
        end else e_err = 1;
      end
      a = (q ? 1 : 0) + (d ? 4 : 0);
      if (m_credit + a <= MAXC)
        m_credit = m_credit + a;
    end
    #1;
    chk({tag, ".o_drink"}, int'(o_drink), e_dr);
    chk({tag, ".o_snack"}, int'(o_snack), e_sn);
    chk({tag, ".coin_err"}, int'(coin_err), e_err);
    chk({tag, ".num_chg"}, int'(num_chg), e_chg);
    chk({tag, ".credit"}, int'(dut.credit), m_credit);
  endtask

  initial begin
    rst = 1'b1; qtr = 1'b0; dlr = 1'b0;
    sel_dr = 1'b0; sel_sn = 1'b0;
    #1;
    for (int i = 0; i < 5; i++)
      step(1, 0, 0, 0, 0, "reset");
    step(0, 0, 0, 1, 0, "dr_empty");

    for (int i = 0; i < 3; i++)
      step(0, 1, 0, 0, 0, "q3");
    step(0, 0, 0, 0, 1, "sn_short");
    step(0, 0, 1, 0, 0, "dlr7");
    step(0, 0, 0, 0, 1, "sn_ok7");

    step(0, 0, 0, 1, 0, "dr_0");
    for (int i = 1; i <= 3; i++) begin
      step(0, 1, 0, 0, 0, "q_in");
      step(0, 0, 0, 1, 0, "dr_try");
    end

    step(0, 0, 1, 0, 0, "d1");
    step(0, 0, 1, 0, 0, "d2");
    step(0, 1, 0, 0, 0, "q9");
    step(0, 1, 0, 0, 0, "q10");
    step(0, 1, 0, 0, 0, "q_cap");
    step(0, 0, 0, 1, 0, "dr_chg7");

    step(0, 1, 1, 0, 0, "qd5");
    step(0, 0, 0, 0, 1, "sn_exact");
    step(0, 1, 1, 0, 0, "qd5b");
    step(0, 0, 0, 1, 1, "both_sel");

    step(0, 0, 1, 0, 0, "d4");
    step(1, 0, 0, 0, 0, "rst_mid");
    step(0, 0, 0, 1, 0, "dr_after_rst");
    step(0, 1, 0, 0, 0, "q1");
    step(0, 1, 0, 0, 0, "q2");
    step(0, 1, 0, 0, 0, "q3b");
    step(0, 0, 1, 1, 0, "dr_plus_dlr");
    step(0, 1, 1, 0, 1, "err_plus_coin");

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 5) == 0),
           "rand");
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
